// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, FSM states,
// instruction classes and datapath select values.
package rv32i_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StTrap
  } state_t;

  typedef enum logic [3:0] {
    ClsOp,
    ClsOpImm,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc,
    ClsIllegal
  } op_class_t;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b1000;

  localparam logic [1:0] PcPlus4      = 2'd0;
  localparam logic [1:0] PcBranch     = 2'd1;
  localparam logic [1:0] PcAluAligned = 2'd2;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbLoad = 2'd1;
  localparam logic [1:0] WbPc4  = 2'd2;
  localparam logic [1:0] WbImm  = 2'd3;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmU = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  typedef enum logic [1:0] {
    TrapNone,
    TrapIllegal,
    TrapImemTimeout,
    TrapDmemTimeout
  } trap_cause_t;

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Instruction/data memory request-acknowledge handshake between the control unit
// (master) and the memory system (slave).
interface rv32i_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/rv32i_decoder.sv
// Combinational RV32I instruction classifier: class, legality, ALU op and
// immediate format. FENCE and SYSTEM are reported illegal.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output op_class_t   op_class,
  output logic        legal,
  output logic [3:0]  alu_control,
  output logic [2:0]  imm_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields matter to the datapath, not to the decode.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    op_class    = ClsIllegal;
    legal       = 1'b0;
    alu_control = AluAdd;
    imm_sel     = ImmI;
    unique case (opcode)
      OpcOp: begin
        op_class    = ClsOp;
        legal       = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        alu_control = {instr[30], funct3};
      end
      OpcOpImm: begin
        op_class    = ClsOpImm;
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          legal = 1'b1;
        end
        // Only SRAI carries an op modifier; bit 30 is immediate data otherwise.
        alu_control = {(funct3 == 3'b101) & instr[30], funct3};
      end
      OpcLoad: begin
        op_class = ClsLoad;
        legal    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OpcStore: begin
        op_class = ClsStore;
        legal    = funct3 inside {3'b000, 3'b001, 3'b010};
        imm_sel  = ImmS;
      end
      OpcBranch: begin
        op_class    = ClsBranch;
        legal       = !(funct3 inside {3'b010, 3'b011});
        alu_control = AluSub;
        imm_sel     = ImmB;
      end
      OpcJal: begin
        op_class = ClsJal;
        legal    = 1'b1;
        imm_sel  = ImmJ;
      end
      OpcJalr: begin
        op_class = ClsJalr;
        legal    = (funct3 == 3'b000);
      end
      OpcLui: begin
        op_class = ClsLui;
        legal    = 1'b1;
        imm_sel  = ImmU;
      end
      OpcAuipc: begin
        op_class = ClsAuipc;
        legal    = 1'b1;
        imm_sel  = ImmU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and traps on illegal encodings or memory timeouts.
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          ENABLE_TIMEOUT = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [31:0]                    instr,
  input  logic                           branch_taken,
  rv32i_multicycle_ctrl_if.master        mem,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic [1:0]                     pc_src,
  output logic                           alu_src_a,
  output logic                           alu_src_b,
  output logic [3:0]                     alu_control,
  output logic [2:0]                     imm_sel,
  output logic                           reg_write,
  output logic [1:0]                     wb_sel,
  output logic                           halted,
  output logic [1:0]                     trap_cause
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  trap_cause_t trap_cause_q;
  logic [7:0]  wait_cnt_q;

  op_class_t   dec_class;
  logic        dec_legal;
  logic [3:0]  dec_alu_control;
  logic [2:0]  dec_imm_sel;

  logic        timeout_hit;
  logic        uses_imm;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;

  rv32i_decoder u_decoder (
    .instr       (instr),
    .op_class    (dec_class),
    .legal       (dec_legal),
    .alu_control (dec_alu_control),
    .imm_sel     (dec_imm_sel)
  );

  // The ack is checked before this, so an ack on the final allowed cycle still wins.
  assign timeout_hit = ENABLE_TIMEOUT && (wait_cnt_q == TimeoutLast);
  assign uses_imm    = dec_class inside {ClsOpImm, ClsLoad, ClsStore, ClsJalr, ClsAuipc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      trap_cause_q <= TrapNone;
      wait_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q    <= StFetch;
          wait_cnt_q <= '0;
        end
        StFetch: begin
          if (mem.imem_ack) begin
            state_q <= StDecode;
          end else if (timeout_hit) begin
            state_q      <= StTrap;
            trap_cause_q <= TrapImemTimeout;
          end else if (wait_cnt_q != 8'hff) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StDecode: begin
          if (dec_legal) begin
            state_q <= StExecute;
          end else begin
            state_q      <= StTrap;
            trap_cause_q <= TrapIllegal;
          end
        end
        StExecute: begin
          wait_cnt_q <= '0;
          if (dec_class == ClsBranch) begin
            state_q <= StFetch;
          end else if (dec_class inside {ClsLoad, ClsStore}) begin
            state_q <= StMem;
          end else begin
            state_q <= StWriteback;
          end
        end
        StMem: begin
          if (mem.dmem_ack) begin
            state_q    <= (dec_class == ClsLoad) ? StWriteback : StFetch;
            wait_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q      <= StTrap;
            trap_cause_q <= TrapDmemTimeout;
          end else if (wait_cnt_q != 8'hff) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StWriteback: begin
          state_q    <= StFetch;
          wait_cnt_q <= '0;
        end
        StTrap: state_q <= StTrap;
        default: state_q <= StTrap;
      endcase
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PcPlus4;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    alu_control = AluAdd;
    imm_sel     = ImmI;
    reg_write   = 1'b0;
    wb_sel      = WbAlu;
    halted      = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_write = mem.imem_ack;
      end
      StDecode: begin
        alu_control = dec_alu_control;
        imm_sel     = dec_imm_sel;
      end
      StExecute: begin
        alu_control = dec_alu_control;
        imm_sel     = dec_imm_sel;
        alu_src_a   = (dec_class == ClsAuipc);
        alu_src_b   = uses_imm;
        if (dec_class == ClsBranch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PcBranch : PcPlus4;
        end
      end
      StMem: begin
        alu_control = dec_alu_control;
        imm_sel     = dec_imm_sel;
        alu_src_b   = 1'b1;
        dmem_req    = 1'b1;
        dmem_we     = (dec_class == ClsStore);
        // A store retires on its ack; it has no writeback cycle.
        if ((dec_class == ClsStore) && mem.dmem_ack) begin
          pc_write = 1'b1;
        end
      end
      StWriteback: begin
        alu_control = dec_alu_control;
        imm_sel     = dec_imm_sel;
        alu_src_a   = (dec_class == ClsAuipc);
        alu_src_b   = uses_imm;
        reg_write   = (instr[11:7] != 5'd0);
        pc_write    = 1'b1;
        unique case (dec_class)
          ClsLoad:         wb_sel = WbLoad;
          ClsJal, ClsJalr: wb_sel = WbPc4;
          ClsLui:          wb_sel = WbImm;
          default:         wb_sel = WbAlu;
        endcase
        unique case (dec_class)
          ClsJal:  pc_src = PcBranch;
          ClsJalr: pc_src = PcAluAligned;
          default: pc_src = PcPlus4;
        endcase
      end
      StTrap: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.imem_req = imem_req;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;
  assign trap_cause   = trap_cause_q;

endmodule

// File: doc/rv32i_multicycle_ctrl.md
# rv32i_multicycle_ctrl

Multi-cycle control unit for the RV32I core, replacing the single-cycle immediate-ALU decoder. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath select lines and handshakes with instruction and data memory. It covers all nine RV32I base opcode classes, excluding FENCE and SYSTEM. It traps on illegal encodings and on memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, 16: wait cycles allowed on a memory request before a timeout trap; range 1..255.
- `ENABLE_TIMEOUT`, 1: 0 disables the timeout; requests then wait forever.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction register contents; valid from DECODE onward.
- `branch_taken` in 1: comparator result for the current branch's funct3; sampled in EXECUTE.
- `imem_ack`, `dmem_ack` in 1: memory acknowledge.
- `imem_req`, `dmem_req` out 1: memory request; `dmem_we` out 1: store.
- `ir_write` out 1: latch `instr` from the instruction bus.
- `pc_write` out 1; `pc_src` out 2: 0 = pc+4, 1 = pc+imm, 2 = ALU result with bit 0 cleared.
- `alu_src_a` out 1: 0 = rs1, 1 = pc.
- `alu_src_b` out 1: 0 = rs2, 1 = imm.
- `alu_control` out 4: {op-modifier bit, funct3}.
- `imm_sel` out 3: 0 I, 1 S, 2 B, 3 U, 4 J.
- `reg_write` out 1; `wb_sel` out 2: 0 ALU, 1 load data, 2 pc+4, 3 imm.
- `halted` out 1; `trap_cause` out 2: 0 none, 1 illegal, 2 imem timeout, 3 dmem timeout.

## Operation
- States are BOOT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- Reset: state is BOOT and `trap_cause` is 0. Every output is 0 while in BOOT.
- BOOT→FETCH unconditionally, on the first edge after reset release.
- FETCH:
  - `imem_req` stays high until `imem_ack`.
  - An ack in the same cycle counts.
  - On ack: `ir_write` pulses that cycle, then →DECODE.
- DECODE: legality check.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Load funct3 ∈ {000,001,010,100,101}; store funct3 ∈ {000,001,010}.
  - Branch funct3 ∉ {010,011}; JALR funct3 = 000.
  - R-type funct7 ∈ {0000000, 0100000}; 0100000 only with funct3 000 or 101.
  - I-type shifts: funct7 = 0000000 for funct3 001; funct7 ∈ {0000000, 0100000} for funct3 101.
  - Illegal →TRAP with cause 1; legal →EXECUTE.
- `alu_control` encoding:
  - R-type: {instr[30], funct3}.
  - I-type ALU: {instr[30] if funct3 = 101, else 0; funct3}.
  - Branch: 4'b1000 (SUB).
  - All others: 4'b0000 (ADD).
- EXECUTE:
  - Branch: `pc_write`=1, `pc_src` = `branch_taken` ? 1 : 0, →FETCH.
  - Load/store: ALU computes rs1+imm, →MEM.
  - Everything else →WRITEBACK.
  - AUIPC sets `alu_src_a`=1.
- MEM:
  - `dmem_req` held until `dmem_ack`; `dmem_we`=1 for stores.
  - Load →WRITEBACK.
  - Store: `pc_write`=1, `pc_src`=0, →FETCH.
- WRITEBACK:
  - `reg_write` = (rd ≠ 0).
  - `wb_sel`: load 1, JAL/JALR 2, LUI 3, otherwise 0.
  - `pc_write`=1; `pc_src`: JAL 1, JALR 2, otherwise 0. Then →FETCH.
  - JALR recomputes rs1+imm in the ALU during WRITEBACK.
- TRAP:
  - Absorbing; only reset leaves it.
  - `halted`=1; `trap_cause` holds its value; every other output is 0.
- Timeout:
  - A saturating wait counter is cleared on entry to FETCH/MEM and increments each cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES` without ack: →TRAP, cause 2 (FETCH) or 3 (MEM).
  - An ack arriving in the same cycle as the limit wins.

## Timing
- Outputs are combinational from the registered state and `instr`. State updates on the rising edge of `clk`.
- Cycles per instruction with zero-wait acks:
  - Branch: 3.
  - ALU, LUI, AUIPC, JAL, JALR, store: 4.
  - Load: 5.
- Each memory wait cycle adds 1 cycle.
- `pc_write` is asserted exactly once per retired instruction; `ir_write` exactly once per fetch.
- Reset asserted mid-instruction: immediate return to BOOT, outputs drop to 0 asynchronously, `trap_cause` clears.

## Structure
- `rv32i_pkg` holds:
  - the opcode localparams;
  - the `state_t` enum;
  - the ALU op, `pc_src`, `wb_sel` and `imm_sel` encodings;
  - the `trap_cause_t` enum.
- Sub-module `rv32i_decoder` is purely combinational. It takes `instr` and produces class, `legal`, `alu_control` and `imm_sel`.
- The FSM, wait counter and output decode live in the top module.

## Test plan
- `addi x1,x0,5` (0x00500093), zero-wait acks → `ir_write` in cycle 1; `reg_write`=1, `wb_sel`=0 in cycle 4; `pc_write`, `pc_src`=0 in cycle 4.
- `lw x2,4(x1)` with `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_we`=0, `wb_sel`=1; 8 cycles total.
- `beq` with `branch_taken`=1, then with `branch_taken`=0 → `pc_src`=1 and `pc_src`=0 respectively in the EXECUTE cycle; `reg_write` never asserted.
- Instruction 0x0000707F (illegal opcode), and R-type `sub` with funct3 001 → TRAP, `trap_cause`=1, `halted`=1, held for 20 cycles.
- `imem_ack` never asserted, `TIMEOUT_CYCLES`=16 → `trap_cause`=2 after 16 cycles of `imem_req` with no ack. With the ack arriving on cycle 16 instead → normal DECODE.
- `rst_n` pulsed low during MEM of a store → `dmem_req` drops immediately; BOOT, then FETCH on the cycle after release; no `pc_write` from the aborted store.
